// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - reset-time flash-to-RAM2 image copier with running checksum
module flash_boot_loader #(
    parameter logic [15:0] BOOT_WORDS = 16'd4096,
    parameter logic [21:0] FLASH_BASE = 22'h000000,
    parameter logic [17:0] RAM_BASE   = 18'h00000,
    parameter logic [3:0]  FLASH_WAIT = 4'd8,
    parameter logic [3:0]  RAM_WAIT   = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        skip_i,
    output logic [21:0] flash_addr_o,
    output logic        flash_read_o,
    input  logic [15:0] flash_data_i,
    output logic        ram_enable_o,
    output logic        ram_readWrite_o,
    output logic [17:0] ram_address_o,
    output logic [15:0] ram_data_o,
    output logic        cpu_hold_o,
    output logic        boot_done_o,
    output logic [15:0] words_done_o,
    output logic [15:0] checksum_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FLASH_READ = 3'd1;
    localparam logic [2:0] S_RAM_WRITE  = 3'd2;
    localparam logic [2:0] S_NEXT       = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    // A zero wait is treated as one cycle, so the reload value saturates at 0.
    localparam logic [3:0] FLASH_LOAD = (FLASH_WAIT == 4'd0) ? 4'd0 : FLASH_WAIT - 4'd1;
    localparam logic [3:0] RAM_LOAD   = (RAM_WAIT == 4'd0) ? 4'd0 : RAM_WAIT - 4'd1;

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic [15:0] idx;
    logic [15:0] idx_next;

    assign idx_next = idx + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wait_cnt        <= 4'd0;
            idx             <= 16'd0;
            flash_addr_o    <= 22'd0;
            flash_read_o    <= 1'b0;
            ram_enable_o    <= 1'b0;
            ram_readWrite_o <= 1'b0;
            ram_address_o   <= 18'd0;
            ram_data_o      <= 16'd0;
            cpu_hold_o      <= 1'b1;
            boot_done_o     <= 1'b0;
            words_done_o    <= 16'd0;
            checksum_o      <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (skip_i || BOOT_WORDS == 16'd0) begin
                        state       <= S_DONE;
                        cpu_hold_o  <= 1'b0;
                        boot_done_o <= 1'b1;
                    end else begin
                        idx          <= 16'd0;
                        flash_read_o <= 1'b1;
                        flash_addr_o <= FLASH_BASE;
                        wait_cnt     <= FLASH_LOAD;
                        state        <= S_FLASH_READ;
                    end
                end
                S_FLASH_READ: begin
                    if (wait_cnt == 4'd0) begin
                        ram_data_o      <= flash_data_i;
                        flash_read_o    <= 1'b0;
                        ram_enable_o    <= 1'b1;
                        ram_readWrite_o <= 1'b1;
                        ram_address_o   <= RAM_BASE + {2'b00, idx};
                        wait_cnt        <= RAM_LOAD;
                        state           <= S_RAM_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RAM_WRITE: begin
                    if (wait_cnt == 4'd0) begin
                        ram_enable_o    <= 1'b0;
                        ram_readWrite_o <= 1'b0;
                        state           <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_NEXT: begin
                    words_done_o <= words_done_o + 16'd1;
                    checksum_o   <= checksum_o + ram_data_o;
                    idx          <= idx_next;
                    if (idx_next == BOOT_WORDS) begin
                        state       <= S_DONE;
                        cpu_hold_o  <= 1'b0;
                        boot_done_o <= 1'b1;
                    end else begin
                        flash_read_o <= 1'b1;
                        flash_addr_o <= FLASH_BASE + {6'd0, idx_next};
                        wait_cnt     <= FLASH_LOAD;
                        state        <= S_FLASH_READ;
                    end
                end
                S_DONE: begin
                    flash_read_o    <= 1'b0;
                    ram_enable_o    <= 1'b0;
                    ram_readWrite_o <= 1'b0;
                    cpu_hold_o      <= 1'b0;
                    boot_done_o     <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - self-checking bench for flash_boot_loader
module tb_flash_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic skip = 1'b0;

    logic        fr[4], en[4], rw[4], hold[4], done[4];
    logic [21:0] fa[4];
    logic [17:0] ra[4];
    logic [15:0] wd[4], wc[4], ck[4], fd[4];

    int checks = 0;
    int errors = 0;

    // Instance 0: main image; 1: empty image; 2: wrapping bases, zero flash wait; 3: all-ones data
    logic [15:0] table_a[16];
    assign fd[0] = table_a[fa[0][3:0]];
    assign fd[1] = 16'h0000;
    assign fd[2] = fa[2][15:0] ^ 16'hA5A5;
    assign fd[3] = 16'hFFFF;

    flash_boot_loader #(.BOOT_WORDS(16'd4), .FLASH_BASE(22'h000000), .RAM_BASE(18'h00000),
                        .FLASH_WAIT(4'd3), .RAM_WAIT(4'd2)) u_a (
        .clk(clk), .rst(rst), .skip_i(skip), .flash_addr_o(fa[0]), .flash_read_o(fr[0]),
        .flash_data_i(fd[0]), .ram_enable_o(en[0]), .ram_readWrite_o(rw[0]), .ram_address_o(ra[0]),
        .ram_data_o(wd[0]), .cpu_hold_o(hold[0]), .boot_done_o(done[0]), .words_done_o(wc[0]),
        .checksum_o(ck[0]));

    flash_boot_loader #(.BOOT_WORDS(16'd0), .FLASH_BASE(22'h000000), .RAM_BASE(18'h00000),
                        .FLASH_WAIT(4'd3), .RAM_WAIT(4'd2)) u_z (
        .clk(clk), .rst(rst), .skip_i(skip), .flash_addr_o(fa[1]), .flash_read_o(fr[1]),
        .flash_data_i(fd[1]), .ram_enable_o(en[1]), .ram_readWrite_o(rw[1]), .ram_address_o(ra[1]),
        .ram_data_o(wd[1]), .cpu_hold_o(hold[1]), .boot_done_o(done[1]), .words_done_o(wc[1]),
        .checksum_o(ck[1]));

    flash_boot_loader #(.BOOT_WORDS(16'd3), .FLASH_BASE(22'h3FFFFE), .RAM_BASE(18'h3FFFF),
                        .FLASH_WAIT(4'd0), .RAM_WAIT(4'd1)) u_w (
        .clk(clk), .rst(rst), .skip_i(skip), .flash_addr_o(fa[2]), .flash_read_o(fr[2]),
        .flash_data_i(fd[2]), .ram_enable_o(en[2]), .ram_readWrite_o(rw[2]), .ram_address_o(ra[2]),
        .ram_data_o(wd[2]), .cpu_hold_o(hold[2]), .boot_done_o(done[2]), .words_done_o(wc[2]),
        .checksum_o(ck[2]));

    flash_boot_loader #(.BOOT_WORDS(16'd2), .FLASH_BASE(22'h000010), .RAM_BASE(18'h00100),
                        .FLASH_WAIT(4'd2), .RAM_WAIT(4'd3)) u_f (
        .clk(clk), .rst(rst), .skip_i(skip), .flash_addr_o(fa[3]), .flash_read_o(fr[3]),
        .flash_data_i(fd[3]), .ram_enable_o(en[3]), .ram_readWrite_o(rw[3]), .ram_address_o(ra[3]),
        .ram_data_o(wd[3]), .cpu_hold_o(hold[3]), .boot_done_o(done[3]), .words_done_o(wc[3]),
        .checksum_o(ck[3]));

    // Bus monitor: logs each RAM write window and flash read burst, tallies protocol violations.
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    logic        en_prev[4], fr_prev[4];
    logic [17:0] w_addr[4][16];
    logic [15:0] w_data[4][16];
    logic [21:0] f_addr[4][16];
    logic [17:0] win_a[4];
    logic [15:0] win_d[4];
    int w_cnt[4], f_cnt[4], strobes[4];
    int viol_overlap = 0, viol_hold = 0, viol_stable = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_q) begin
                w_cnt[i] = 0; f_cnt[i] = 0; strobes[i] = 0;
                en_prev[i] = 1'b0; fr_prev[i] = 1'b0;
            end else begin
                if (fr[i] && en[i]) viol_overlap++;
                if (hold[i] == done[i]) viol_hold++;
                if (fr[i] || en[i] || rw[i]) strobes[i]++;
                if (en[i] && !rw[i]) viol_stable++;
                if (fr[i] && !fr_prev[i]) begin
                    if (f_cnt[i] < 16) f_addr[i][f_cnt[i]] = fa[i];
                    f_cnt[i]++;
                end
                if (en[i] && !en_prev[i]) begin
                    if (w_cnt[i] < 16) begin
                        w_addr[i][w_cnt[i]] = ra[i];
                        w_data[i][w_cnt[i]] = wd[i];
                    end
                    w_cnt[i]++;
                    win_a[i] = ra[i];
                    win_d[i] = wd[i];
                end else if (en[i] && (ra[i] !== win_a[i] || wd[i] !== win_d[i])) begin
                    viol_stable++;
                end
                en_prev[i] = en[i];
                fr_prev[i] = fr[i];
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (done[i]) begin ok = 1'b1; break; end
        end
    endtask

    function automatic int expected_edges(int words, int fw, int rwt);
        return 1 + words * ((fw < 1 ? 1 : fw) + (rwt < 1 ? 1 : rwt) + 1);
    endfunction

    function automatic logic [15:0] sum_table(int words);
        int s = 0;
        for (int k = 0; k < words; k++) s += int'(table_a[k]);
        return s[15:0];
    endfunction

    task automatic check_main_copy(input string tag, input int n, input bit ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: boot_done never rose", tag); end
        checks++; if (n !== expected_edges(4, 3, 2)) begin errors++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", tag, n, expected_edges(4, 3, 2)); end
        checks++; if (hold[0] !== 1'b0) begin errors++; $display("FAIL %s_hold: got %b, expected 0", tag, hold[0]); end
        checks++; if (w_cnt[0] !== 4) begin errors++; $display("FAIL %s_wcount: got %0d, expected 4", tag, w_cnt[0]); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w_addr[0][k] !== 18'(k) || w_data[0][k] !== table_a[k]) begin errors++;
                $display("FAIL %s_write%0d: got %h/%h, expected %h/%h", tag, k, w_addr[0][k], w_data[0][k], 18'(k), table_a[k]); end
        end
        checks++; if (ck[0] !== sum_table(4)) begin errors++;
            $display("FAIL %s_checksum: got %h, expected %h", tag, ck[0], sum_table(4)); end
        checks++; if (wc[0] !== 16'd4) begin errors++; $display("FAIL %s_words: got %0d, expected 4", tag, wc[0]); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fr[0], en[0], rw[0], hold[0], done[0]} !== 5'b00010) begin errors++;
            $display("FAIL reset_ctrl: got %b, expected 00010", {fr[0], en[0], rw[0], hold[0], done[0]}); end
        checks++;
        if ({fa[0], ra[0], wd[0], wc[0], ck[0]} !== '0) begin errors++;
            $display("FAIL reset_data: got %h %h %h %h %h, expected all 0", fa[0], ra[0], wd[0], wc[0], ck[0]); end
    endtask

    task automatic test_basic();
        int n; bit ok;
        for (int k = 0; k < 16; k++) table_a[k] = 16'h1000 + 16'(k);
        skip = 1'b0;
        do_reset();
        wait_done(0, 200, n, ok);
        check_main_copy("basic", n, ok);
        checks++; if (ck[0] !== 16'h4006) begin errors++; $display("FAIL basic_known_sum: got %h, expected 4006", ck[0]); end
        checks++; if (f_cnt[0] !== 4 || f_addr[0][3] !== 22'd3) begin errors++;
            $display("FAIL basic_flash: got %0d reads last %h, expected 4 reads last 3", f_cnt[0], f_addr[0][3]); end
        checks++; if (wd[0] !== table_a[3]) begin errors++; $display("FAIL basic_hold_data: got %h, expected %h", wd[0], table_a[3]); end
    endtask

    task automatic test_skip();
        skip = 1'b1;
        do_reset();
        @(posedge clk); #1;
        checks++; if (done[0] !== 1'b1 || hold[0] !== 1'b0) begin errors++;
            $display("FAIL skip_done: got done=%b hold=%b, expected 1/0", done[0], hold[0]); end
        repeat (30) @(posedge clk);
        #1;
        checks++; if (strobes[0] !== 0) begin errors++; $display("FAIL skip_strobes: got %0d, expected 0", strobes[0]); end
        checks++; if (ck[0] !== 16'h0 || wc[0] !== 16'h0) begin errors++;
            $display("FAIL skip_counts: got %h/%h, expected 0/0", ck[0], wc[0]); end
        skip = 1'b0;
    endtask

    task automatic test_zero_words();
        do_reset();
        @(posedge clk); #1;
        checks++; if (done[1] !== 1'b1 || hold[1] !== 1'b0) begin errors++;
            $display("FAIL zero_done: got done=%b hold=%b, expected 1/0", done[1], hold[1]); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (strobes[1] !== 0) begin errors++; $display("FAIL zero_strobes: got %0d, expected 0", strobes[1]); end
    endtask

    task automatic test_wrap();
        int n; bit ok;
        logic [21:0] exp_f;
        logic [17:0] exp_r;
        logic [15:0] exp_sum;
        do_reset();
        wait_done(2, 200, n, ok);
        checks++; if (!ok || n !== expected_edges(3, 0, 1)) begin errors++;
            $display("FAIL wrap_latency: got %0d edges, expected %0d", n, expected_edges(3, 0, 1)); end
        checks++; if (f_cnt[2] !== 3 || w_cnt[2] !== 3) begin errors++;
            $display("FAIL wrap_counts: got %0d reads %0d writes, expected 3/3", f_cnt[2], w_cnt[2]); end
        exp_sum = 16'h0;
        for (int k = 0; k < 3; k++) begin
            exp_f = 22'h3FFFFE + 22'(k);
            exp_r = 18'h3FFFF + 18'(k);
            exp_sum = exp_sum + (exp_f[15:0] ^ 16'hA5A5);
            checks++;
            if (f_addr[2][k] !== exp_f || w_addr[2][k] !== exp_r || w_data[2][k] !== (exp_f[15:0] ^ 16'hA5A5)) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h/%h/%h, expected %h/%h/%h", k, f_addr[2][k], w_addr[2][k],
                         w_data[2][k], exp_f, exp_r, exp_f[15:0] ^ 16'hA5A5);
            end
        end
        checks++; if (ck[2] !== exp_sum) begin errors++; $display("FAIL wrap_checksum: got %h, expected %h", ck[2], exp_sum); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit found;
        for (int k = 0; k < 16; k++) table_a[k] = 16'h1000 + 16'(k);
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (en[0] && ra[0] == 18'd2) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_reach: word 2 write not seen, expected it"); end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({fr[0], en[0], rw[0], hold[0], done[0]} !== 5'b00010 || {fa[0], ra[0], wd[0], wc[0], ck[0]} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl %b data %h %h %h %h %h, expected 00010 and zeros",
                     {fr[0], en[0], rw[0], hold[0], done[0]}, fa[0], ra[0], wd[0], wc[0], ck[0]);
        end
        #1 rst = 1'b0;
        wait_done(0, 200, n, ok);
        check_main_copy("midrst", n, ok);
    endtask

    task automatic test_ones();
        int n; bit ok;
        do_reset();
        wait_done(3, 200, n, ok);
        checks++; if (!ok || n !== expected_edges(2, 2, 3)) begin errors++;
            $display("FAIL ones_latency: got %0d edges, expected %0d", n, expected_edges(2, 2, 3)); end
        checks++; if (ck[3] !== 16'hFFFE) begin errors++; $display("FAIL ones_checksum: got %h, expected fffe", ck[3]); end
        checks++;
        if (w_cnt[3] !== 2 || w_data[3][0] !== 16'hFFFF || w_data[3][1] !== 16'hFFFF
            || w_addr[3][0] !== 18'h00100 || w_addr[3][1] !== 18'h00101) begin
            errors++;
            $display("FAIL ones_writes: got %0d writes %h@%h %h@%h, expected ffff@100 ffff@101",
                     w_cnt[3], w_data[3][0], w_addr[3][0], w_data[3][1], w_addr[3][1]);
        end
    endtask

    task automatic test_random();
        int n; bit ok;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 16; k++) table_a[k] = 16'($urandom);
            skip = 1'b0;
            do_reset();
            n = 0; ok = 1'b0;
            while (n < 200) begin
                @(posedge clk); #1;
                n++;
                if (done[0]) begin ok = 1'b1; break; end
                skip = 1'($urandom_range(0, 1));
            end
            skip = 1'b0;
            check_main_copy("random", n, ok);
        end
    endtask

    task automatic test_invariants();
        checks++; if (viol_overlap !== 0) begin errors++; $display("FAIL inv_overlap: got %0d, expected 0", viol_overlap); end
        checks++; if (viol_hold !== 0) begin errors++; $display("FAIL inv_hold_done: got %0d, expected 0", viol_hold); end
        checks++; if (viol_stable !== 0) begin errors++; $display("FAIL inv_write_stable: got %0d, expected 0", viol_stable); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) table_a[k] = 16'h0;
        test_reset();
        test_basic();
        test_skip();
        test_zero_words();
        test_wrap();
        test_reset_mid();
        test_ones();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
Reset-time sequencer that copies a fixed image from flash into RAM2 before the CPU runs. It drives the flash_io read interface and the ram_control write interface, and holds the CPU and mem_bridge off the RAM path until the copy completes. It sits between flash_io, mem_bridge/mmu and ram_control. The top level muxes the RAM request lines to this block while cpu_hold_o is high. It also produces a running 16-bit checksum so software and the LEDs can confirm a good boot.

Parameters:
BOOT_WORDS, 16'd4096, number of 16-bit words to copy (0 allowed)
FLASH_BASE, 22'h000000, first flash word address (flash_addr[22:1])
RAM_BASE, 18'h00000, first RAM2 word address
FLASH_WAIT, 4'd8, cycles flash_read_o is held high per word (>=1)
RAM_WAIT, 4'd2, cycles each RAM write is held (>=1)

Ports:
clk  in  1  system clock (clk_full domain)
rst  in  1  synchronous reset, active-high
skip_i  in  1  boot bypass (tied to a switch); sampled only in IDLE
flash_addr_o  out  22  flash word address, flash_addr[22:1]
flash_read_o  out  1  read strobe to flash_io ctl_read
flash_data_i  in  16  read data from flash_io data_out
ram_enable_o  out  1  RAM request enable to ram_control
ram_readWrite_o  out  1  1 = write, 0 = read; driven 1 only in RAM_WRITE
ram_address_o  out  18  RAM2 word address
ram_data_o  out  16  RAM write data
cpu_hold_o  out  1  high while copying; holds CPU and selects this block's RAM path
boot_done_o  out  1  high once copy finished or skipped; sticky until rst
words_done_o  out  16  count of words fully written
checksum_o  out  16  mod-2^16 sum of all written words

Behaviour:
- Clock is clk; reset is synchronous, active-high. Both are already decided.
- Reset values: state=IDLE; flash_read_o=0; ram_enable_o=0; ram_readWrite_o=0; all address, data and counter outputs=0; cpu_hold_o=1; boot_done_o=0.
- States: IDLE, FLASH_READ, RAM_WRITE, NEXT, DONE. One transition per clock edge.
- IDLE (1 cycle):
  - skip_i=1 or BOOT_WORDS=0 -> DONE.
  - Otherwise load idx=0 -> FLASH_READ.
- FLASH_READ (FLASH_WAIT cycles):
  - flash_read_o=1; flash_addr_o = FLASH_BASE+idx, truncated to 22 bits (wraps).
  - On the edge ending the last cycle: latch flash_data_i into the data register, drop flash_read_o -> RAM_WRITE.
- RAM_WRITE (RAM_WAIT cycles):
  - ram_enable_o=1, ram_readWrite_o=1.
  - ram_address_o = RAM_BASE+idx, truncated to 18 bits (wraps).
  - ram_data_o = data register, stable for the whole state.
  - Then -> NEXT.
- NEXT (1 cycle):
  - ram_enable_o=0; words_done_o += 1; checksum_o += data register (mod 2^16); idx += 1.
  - If the new idx == BOOT_WORDS -> DONE, else -> FLASH_READ.
- DONE (terminal):
  - cpu_hold_o=0, boot_done_o=1; all strobes 0.
  - Address, data and counter outputs hold their last values.
- Timing: with copy active, boot_done_o rises exactly 1 + BOOT_WORDS*(FLASH_WAIT+RAM_WAIT+1) edges after the first edge sampled with rst=0. With skip, it rises after 1 edge.
- Wait counters are 4-bit, down-counting and reloaded on each state entry. FLASH_WAIT or RAM_WAIT = 0 is illegal; behave as 1.
- cpu_hold_o and boot_done_o are never both 1, and never both 0 after the first post-reset edge.
- flash_read_o and ram_enable_o are never high in the same cycle.
- rst asserted mid-copy: next edge returns all outputs to reset values. The copy restarts from word 0 when rst drops; partially written RAM is simply overwritten.
- skip_i changes outside IDLE are ignored.

Test Plan:
1. BOOT_WORDS=4, FLASH_WAIT=3, RAM_WAIT=2, flash model returns data = 16'h1000+addr:
   - RAM writes land at addresses 0..3 with data 1000,1001,1002,1003.
   - checksum_o=16'h4006, words_done_o=4.
   - boot_done_o rises on edge 25 after rst release; cpu_hold_o falls on the same edge.
2. skip_i=1 at reset release: boot_done_o=1 after 1 edge; flash_read_o and ram_enable_o never assert; checksum_o=0.
3. BOOT_WORDS=0: DONE after 1 edge, no strobes.
4. FLASH_BASE=22'h3FFFFE, RAM_BASE=18'h3FFFF, BOOT_WORDS=3:
   - flash addresses 3FFFFE, 3FFFFF, 000000.
   - RAM addresses 3FFFF, 00000, 00001.
5. Assert rst for 1 cycle during word 2's RAM_WRITE:
   - all outputs reset on the next edge.
   - after release, the copy restarts at idx 0 and the final checksum equals the case-1 value.
6. Flash data 16'hFFFF for all words, BOOT_WORDS=2: checksum_o wraps to 16'hFFFE; ram_data_o holds FFFF throughout each RAM_WRITE window.
